// File: rtl/fir_block_scheduler_if.sv
// Sample-in and result-out streams of the FIR block scheduler.
// The slave modport is the scheduler side; master is the producer/consumer side.
interface fir_block_scheduler_if;
  logic        sampleValidIn;
  logic [15:0] sampleDataIn;
  logic        sampleReadyOut;
  logic        resultValidOut;
  logic [31:0] resultDataOut;
  logic        resultReadyIn;

  modport slave (
    input  sampleValidIn, sampleDataIn, resultReadyIn,
    output sampleReadyOut, resultValidOut, resultDataOut
  );

  modport master (
    output sampleValidIn, sampleDataIn, resultReadyIn,
    input  sampleReadyOut, resultValidOut, resultDataOut
  );
endinterface

// File: rtl/fir_block_scheduler.sv
// Double-buffered sample packer and start/done/drain sequencer for the block FIR core.
// Optional WAIT-state watchdog enabled by defining FIR_SCHED_WATCHDOG_EN.
module fir_block_scheduler #(
  parameter int unsigned SAMPLES_NUM    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  fir_block_scheduler_if.slave      stream_io,
  output logic                      firStartOut,
  output logic [16*SAMPLES_NUM-1:0] firDataOut,
  input  logic                      firBusyIn,
  input  logic                      firDoneIn,
  input  logic [32*SAMPLES_NUM-1:0] firDataIn,
  output logic                      errorOut
);
  localparam int unsigned     CntW    = 3;
  localparam logic [CntW-1:0] LastIdx = CntW'(SAMPLES_NUM - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [16*SAMPLES_NUM-1:0] collect_q, collect_d;
  logic [16*SAMPLES_NUM-1:0] pending_q, pending_d;
  logic [16*SAMPLES_NUM-1:0] fir_data_q, fir_data_d;
  logic [32*SAMPLES_NUM-1:0] result_q, result_d;
  logic                      pending_full_q, pending_full_d;
  logic [CntW-1:0]           fill_q, fill_d;
  logic [CntW-1:0]           drain_idx_q, drain_idx_d;
  logic                      error_q, error_d;
  logic                      accept;
  logic                      timeout;
  logic [31:0]               res_word;

`ifdef FIR_SCHED_WATCHDOG_EN
  localparam logic [12:0] TimeoutLast = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] wdog_q, wdog_d;

  assign timeout = (state_q == StWait) && (wdog_q == TimeoutLast);
  assign wdog_d  = (state_q == StWait) ? wdog_q + 13'd1 : 13'd0;

  always_ff @(posedge clkIn) begin
    if (resetIn) wdog_q <= 13'd0;
    else         wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Stall only when both the collect and pending buffers would be full.
  assign stream_io.sampleReadyOut = !resetIn && !(pending_full_q && fill_q == LastIdx);
  assign accept = stream_io.sampleValidIn && stream_io.sampleReadyOut;

  always_comb begin
    state_d        = state_q;
    collect_d      = collect_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    fill_d         = fill_q;
    fir_data_d     = fir_data_q;
    result_d       = result_q;
    drain_idx_d    = drain_idx_q;
    error_d        = error_q;

    unique case (state_q)
      StIdle: begin
        if (pending_full_q && !firBusyIn) begin
          fir_data_d     = pending_q;
          pending_full_d = 1'b0;
          state_d        = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        // A done in the timeout cycle takes priority over the watchdog.
        if (firDoneIn) begin
          result_d    = firDataIn;
          drain_idx_d = '0;
          state_d     = StDrain;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (stream_io.resultReadyIn) begin
          if (drain_idx_q == LastIdx) begin
            drain_idx_d = '0;
            state_d     = StIdle;
          end else begin
            drain_idx_d = drain_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Collector runs after the release so a same-cycle refill keeps pending full.
    if (accept) begin
      for (int i = 0; i < SAMPLES_NUM; i++) begin
        if (fill_q == CntW'(i)) collect_d[16*i +: 16] = stream_io.sampleDataIn;
      end
      if (fill_q == LastIdx) begin
        fill_d         = '0;
        pending_d      = collect_d;
        pending_full_d = 1'b1;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    res_word = 32'd0;
    for (int i = 0; i < SAMPLES_NUM; i++) begin
      if (drain_idx_q == CntW'(i)) res_word = result_q[32*(int'(SAMPLES_NUM)-1-i) +: 32];
    end
  end

  assign firStartOut              = (state_q == StStart);
  assign firDataOut               = fir_data_q;
  assign stream_io.resultValidOut = (state_q == StDrain);
  assign stream_io.resultDataOut  = (state_q == StDrain) ? res_word : 32'd0;
  assign errorOut                 = error_q;

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q        <= StIdle;
      collect_q      <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      fill_q         <= '0;
      fir_data_q     <= '0;
      result_q       <= '0;
      drain_idx_q    <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      collect_q      <= collect_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      fill_q         <= fill_d;
      fir_data_q     <= fir_data_d;
      result_q       <= result_d;
      drain_idx_q    <= drain_idx_d;
      error_q        <= error_d;
    end
  end
endmodule

// File: tb/tb_fir_block_scheduler.sv
// Scoreboard bench for fir_block_scheduler with a behavioural FIR core model.
module tb_fir_block_scheduler;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              fir_start;
  logic [16*N-1:0]   fir_data_o;
  logic              fir_busy, fir_done, err;
  logic [32*N-1:0]   fir_res;
  logic              model_busy, force_busy;

  always #5 clk = ~clk;
  assign fir_busy = model_busy | force_busy;

  fir_block_scheduler_if bus ();

  fir_block_scheduler #(
    .SAMPLES_NUM    (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clkIn       (clk),
    .resetIn     (rst),
    .stream_io   (bus),
    .firStartOut (fir_start),
    .firDataOut  (fir_data_o),
    .firBusyIn   (fir_busy),
    .firDoneIn   (fir_done),
    .firDataIn   (fir_res),
    .errorOut    (err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16*N-1:0]  exp_blk_q[$];
  logic [31:0]      exp_res_q[$];
  logic [32*N-1:0]  core_res_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event required none", name);
  endtask

  // FIR core model: start -> busy for core_latency cycles -> one-cycle done.
  int              core_latency = 10;
  bit              core_no_done = 0;
  int              start_count = 0;
  int              last_start_cyc = -1;
  int              exp_start_cyc = -1;
  initial begin
    logic            prev_start;
    int              cnt;
    logic [32*N-1:0] res_pending;
    logic [15:0]     s;
    prev_start = 1'b0;
    cnt = 0;
    res_pending = '0;
    model_busy = 1'b0;
    fir_done = 1'b0;
    fir_res = '0;
    forever begin
      @(negedge clk);
      fir_done = 1'b0;
      if (fir_start) begin
        start_count++;
        last_start_cyc = cyc;
        check("start_single_pulse", prev_start, 0);
        if (exp_start_cyc >= 0) begin
          check("start_latency", cyc, exp_start_cyc);
          exp_start_cyc = -1;
        end
        if (exp_blk_q.size() == 0) fail("unexpected_start");
        else check("fir_block_data", fir_data_o, exp_blk_q.pop_front());
        if (core_res_q.size() > 0) res_pending = core_res_q.pop_front();
        else begin
          for (int k = 0; k < N; k++) begin
            s = fir_data_o[16*k +: 16];
            res_pending[32*(N-1-k) +: 32] = {~s, s};
          end
        end
        cnt = core_latency;
        model_busy = 1'b1;
      end else if (model_busy) begin
        cnt--;
        if (cnt <= 0) begin
          model_busy = 1'b0;
          fir_done = !core_no_done;
          fir_res = res_pending;
        end
      end
      prev_start = fir_start;
    end
  end

  // Result monitor: pops the scoreboard on every handshake, checks stall stability.
  int hs_count = 0;
  initial begin
    logic        stalled;
    logic [31:0] stall_data;
    stalled = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) begin
          check("stall_valid_hold", bus.resultValidOut, 1);
          check("stall_data_hold", bus.resultDataOut, stall_data);
        end
        if (bus.resultValidOut && bus.resultReadyIn) begin
          hs_count++;
          if (exp_res_q.size() == 0) fail("unexpected_result");
          else check("result_data", bus.resultDataOut, exp_res_q.pop_front());
          stalled = 1'b0;
        end else if (bus.resultValidOut) begin
          stalled = 1'b1;
          stall_data = bus.resultDataOut;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Downstream ready: constant 1, or the 1,0,0,1 pattern during drain.
  bit         rdy_pat_en = 0;
  int         pidx = 0;
  logic [3:0] pat = 4'b1001;
  initial begin
    bus.resultReadyIn = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_pat_en && bus.resultValidOut) begin
        bus.resultReadyIn = pat[pidx];
        pidx = (pidx + 1) % 4;
      end else begin
        bus.resultReadyIn = 1'b1;
      end
    end
  end

  task automatic push_sample(input logic [15:0] d, output int waited);
    waited = 0;
    bus.sampleValidIn = 1'b1;
    bus.sampleDataIn = d;
    @(negedge clk);
    while (!bus.sampleReadyOut && waited < 10000) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.sampleReadyOut) fail("sample_accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [16*N-1:0] blk, input bit push_res,
                            output int w_first, output int w_last);
    int          w;
    logic [15:0] s;
    w_first = 0;
    w_last = 0;
    exp_blk_q.push_back(blk);
    for (int k = 0; k < N; k++) begin
      s = blk[16*k +: 16];
      if (push_res) exp_res_q.push_back({~s, s});
    end
    for (int k = 0; k < N; k++) begin
      push_sample(blk[16*k +: 16], w);
      if (k < N - 1) w_first += w;
      else w_last = w;
    end
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_res_q.size() != 0 || exp_blk_q.size() != 0 || bus.resultValidOut || model_busy)
           && n < budget) begin
      n++;
      @(negedge clk);
    end
    if (n >= budget) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int wf, wl, s0, h0, ls, n;
    bit exp_err;
    exp_err = 0;
    rst = 1'b1;
    force_busy = 1'b0;
    bus.sampleValidIn = 1'b0;
    bus.sampleDataIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start", fir_start, 0);
    check("rst_fir_data", fir_data_o, 0);
    check("rst_result_valid", bus.resultValidOut, 0);
    check("rst_result_data", bus.resultDataOut, 0);
    check("rst_error", err, 0);
    check("rst_ready", bus.sampleReadyOut, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.sampleReadyOut, 1);
    @(posedge clk);
    #1;

    // Basic block, start two cycles after the last sample, MSW-first drain.
    send_block(64'h0004_0003_0002_0001, 1, wf, wl);
    exp_start_cyc = cyc + 1;
    bus.sampleValidIn = 1'b0;
    check("t1_no_stall", wf + wl, 0);
    wait_quiet(500);
    check("t1_starts", start_count, 1);

    // Long core busy: third block stalls on its last sample until block 1 drains.
    core_latency = 2000;
    send_block(64'h1003_1002_1001_1000, 1, wf, wl);
    check("t2_b1_no_stall", wf + wl, 0);
    send_block(64'h2003_2002_2001_2000, 1, wf, wl);
    check("t2_b2_no_stall", wf + wl, 0);
    send_block(64'h3003_3002_3001_3000, 1, wf, wl);
    check("t2_b3_first_no_stall", wf, 0);
    check("t2_b3_last_stalled", wl > 1000, 1);
    bus.sampleValidIn = 1'b0;
    core_latency = 10;
    wait_quiet(20000);
    check("t2_starts", start_count, 4);

    // Saturation-extreme results with downstream back-pressure.
    core_res_q.push_back({32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002});
    exp_res_q.push_back(32'h7FFF_FFFF);
    exp_res_q.push_back(32'h8000_0000);
    exp_res_q.push_back(32'h0000_0001);
    exp_res_q.push_back(32'h0000_0002);
    pidx = 0;
    rdy_pat_en = 1;
    h0 = hs_count;
    send_block(64'h0BAD_CAFE_8000_7FFF, 0, wf, wl);
    bus.sampleValidIn = 1'b0;
    wait_quiet(500);
    rdy_pat_en = 0;
    check("t3_handshakes", hs_count - h0, 4);
    @(negedge clk);
    check("t3_idle_no_valid", bus.resultValidOut, 0);
    @(posedge clk);
    #1;

    // Reset during WAIT with a partial next block; the late done must be ignored.
    core_latency = 60;
    send_block(64'hAAA3_AAA2_AAA1_AAA0, 1, wf, wl);
    push_sample(16'hBBB0, wf);
    push_sample(16'hBBB1, wf);
    bus.sampleValidIn = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    exp_res_q.delete();
    exp_blk_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t4_rst_start", fir_start, 0);
    check("t4_rst_fir_data", fir_data_o, 0);
    check("t4_rst_result_valid", bus.resultValidOut, 0);
    check("t4_rst_result_data", bus.resultDataOut, 0);
    check("t4_rst_ready", bus.sampleReadyOut, 1);
    @(posedge clk);
    #1;
    s0 = start_count;
    send_block(64'hCCC3_CCC2_CCC1_CCC0, 1, wf, wl);
    bus.sampleValidIn = 1'b0;
    wait_quiet(500);
    check("t4_fresh_start", start_count, s0 + 1);
    core_latency = 10;

    // Busy core holds off the start; start one cycle after busy falls.
    force_busy = 1'b1;
    s0 = start_count;
    send_block(64'h0D03_0D02_0D01_0D00, 1, wf, wl);
    bus.sampleValidIn = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_start_while_busy", start_count, s0);
    @(posedge clk);
    #1 force_busy = 1'b0;
    exp_start_cyc = cyc + 1;
    wait_quiet(500);
    check("t5_start_after_busy", start_count, s0 + 1);

`ifdef FIR_SCHED_WATCHDOG_EN
    // No done: watchdog drops the block and sets the sticky error.
    core_no_done = 1;
    s0 = start_count;
    send_block(64'h0E03_0E02_0E01_0E00, 0, wf, wl);
    bus.sampleValidIn = 1'b0;
    n = 0;
    while (start_count == s0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("wd_started", start_count, s0 + 1);
    ls = last_start_cyc;
    n = 0;
    while (cyc < ls + int'(TO) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("wd_err_before_timeout", err, 0);
    @(negedge clk);
    check("wd_err_at_timeout", err, 1);
    check("wd_no_result", bus.resultValidOut, 0);
    core_no_done = 0;
    exp_err = 1;
    @(posedge clk);
    #1;
    send_block(64'h0F03_0F02_0F01_0F00, 1, wf, wl);
    bus.sampleValidIn = 1'b0;
    wait_quiet(500);
`endif

    check("end_exp_res_empty", exp_res_q.size(), 0);
    check("end_exp_blk_empty", exp_blk_q.size(), 0);
    check("end_start_consumed", exp_start_cyc, -1);
    check("end_error", err, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
